mem_access_ctrl: RTL and testbench

Memory-stage access controller that initiates all load/store traffic to the 64-bit word-addressed data memory. Accepts one request at a time from the pipeline over a valid/ready handshake. Sequences single-word or two-word (pair) reads and writes onto the memory's enable/address/data pins, and absorbs the memory's one-edge registered read latency. Returns a single-cycle response with read data or an error flag.

---
 rtl/mem_access_ctrl_if.sv | 31 +++
 rtl/mem_access_ctrl.sv | 137 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Pipeline request/response handshake plus data-memory pin bundle.
// The controller connects through the slave modport, the requester/memory side through master.
interface mem_access_ctrl_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic         req_pair;
  logic [63:0]  req_addr;
  logic [127:0] req_wdata;
  logic         resp_valid;
  logic         resp_err;
  logic [127:0] resp_rdata;
  logic         busy;
  logic [63:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic         mem_wr_en;
  logic         mem_rd_en;
  logic [63:0]  mem_read_data;

  modport slave (
    input  req_valid, req_write, req_pair, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_err, resp_rdata, busy,
           mem_addr, mem_wdata, mem_wr_en, mem_rd_en
  );

  modport master (
    output req_valid, req_write, req_pair, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_err, resp_rdata, busy,
           mem_addr, mem_wdata, mem_wr_en, mem_rd_en
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store sequencer: single or pair word accesses to a word-addressed
// 64-bit data memory with one-edge registered read latency, one request in flight.
module mem_access_ctrl #(
  parameter int unsigned DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  localparam logic [63:0] LAST_SINGLE = 64'(DEPTH - 1);
  localparam logic [63:0] LAST_PAIR   = 64'(DEPTH - 2);

  state_t       state_q, state_d;
  logic         half_q, half_d;
  logic         write_q, write_d;
  logic         pair_q, pair_d;
  logic         err_q, err_d;
  logic [63:0]  addr_q, addr_d;
  logic [127:0] wdata_q, wdata_d;
  logic [63:0]  rdata_lo_q, rdata_lo_d;
  logic [63:0]  rdata_hi_q, rdata_hi_d;
  logic [63:0]  mem_addr_q, mem_addr_d;
  logic [63:0]  mem_wdata_q, mem_wdata_d;
  logic [127:0] resp_rdata_q, resp_rdata_d;

  logic [63:0]  issue_addr;
  logic [63:0]  issue_wdata;
  logic [127:0] resp_data;
  logic         in_range;

  always_comb begin
    state_d      = state_q;
    half_d       = half_q;
    write_d      = write_q;
    pair_d       = pair_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_lo_d   = rdata_lo_q;
    rdata_hi_d   = rdata_hi_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;

    issue_addr  = addr_q + {63'b0, half_q};
    issue_wdata = half_q ? wdata_q[127:64] : wdata_q[63:0];
    resp_data   = (write_q || err_q) ? 128'b0
                                     : {(pair_q ? rdata_hi_q : 64'b0), rdata_lo_q};
    in_range    = bus.req_pair ? (bus.req_addr <= LAST_PAIR)
                               : (bus.req_addr <= LAST_SINGLE);

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          pair_d  = bus.req_pair;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          half_d  = 1'b0;
          err_d   = !in_range;
          state_d = in_range ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        // Remember what was driven so the pins stay stable once the enables drop.
        mem_addr_d  = issue_addr;
        mem_wdata_d = issue_wdata;
        if (!write_q) begin
          state_d = CAPTURE;
        end else if (pair_q && !half_q) begin
          half_d = 1'b1;
        end else begin
          state_d = RESP;
        end
      end
      CAPTURE: begin
        if (half_q) rdata_hi_d = bus.mem_read_data;
        else        rdata_lo_d = bus.mem_read_data;
        if (pair_q && !half_q) begin
          half_d  = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        resp_rdata_d = resp_data;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      half_q       <= 1'b0;
      write_q      <= 1'b0;
      pair_q       <= 1'b0;
      err_q        <= 1'b0;
      mem_addr_q   <= 64'b0;
      mem_wdata_q  <= 64'b0;
      resp_rdata_q <= 128'b0;
    end else begin
      state_q      <= state_d;
      half_q       <= half_d;
      write_q      <= write_d;
      pair_q       <= pair_d;
      err_q        <= err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q     <= addr_d;
    wdata_q    <= wdata_d;
    rdata_lo_q <= rdata_lo_d;
    rdata_hi_q <= rdata_hi_d;
  end

  // Enables are masked by rst so a reset edge never commits a write or read.
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.resp_rdata = (state_q == RESP) ? resp_data : resp_rdata_q;
  assign bus.mem_wr_en  = (state_q == ISSUE) && write_q && !rst;
  assign bus.mem_rd_en  = (state_q == ISSUE) && !write_q && !rst;
  assign bus.mem_addr   = (state_q == ISSUE) ? issue_addr : mem_addr_q;
  assign bus.mem_wdata  = (state_q == ISSUE) ? issue_wdata : mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table of requests plus hand sequences for
// back-to-back requests while busy and reset in the middle of a pair store.
module tb_mem_access_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.DEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [63:0] mem [0:255];

  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    if (bus.mem_rd_en) bus.mem_read_data <= mem[bus.mem_addr[7:0]];
  end

  typedef struct {
    logic         wr;
    logic         pair;
    logic [63:0]  addr;
    logic [127:0] wdata;
    int           lat;
    logic         err;
    logic [127:0] rdata;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  128'(bus.req_ready),  128'(1));
    chk({tag, "_busy"},   128'(bus.busy),       128'(0));
    chk({tag, "_rvalid"}, 128'(bus.resp_valid), 128'(0));
    chk({tag, "_rerr"},   128'(bus.resp_err),   128'(0));
    chk({tag, "_rdata"},  bus.resp_rdata,       128'(0));
    chk({tag, "_maddr"},  128'(bus.mem_addr),   128'(0));
    chk({tag, "_mwdata"}, 128'(bus.mem_wdata),  128'(0));
    chk({tag, "_wren"},   128'(bus.mem_wr_en),  128'(0));
    chk({tag, "_rden"},   128'(bus.mem_rd_en),  128'(0));
  endtask

  task automatic drive_req(input logic wr, input logic pair, input logic [63:0] addr,
                           input logic [127:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_pair  = pair;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          lat;
    int          en_cnt;
    int          exp_en;
    logic        both;
    logic [63:0] first_addr;
    lat        = 99;
    en_cnt     = 0;
    both       = 1'b0;
    first_addr = 64'b0;
    exp_en     = v.err ? 0 : (v.pair ? 2 : 1);
    @(negedge clk);
    chk($sformatf("v%0d_ready_in", idx), 128'(bus.req_ready), 128'(1));
    drive_req(v.wr, v.pair, v.addr, v.wdata);
    step();
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.mem_wr_en || bus.mem_rd_en) begin
        if (en_cnt == 0) first_addr = bus.mem_addr;
        en_cnt++;
        if (bus.mem_wr_en && bus.mem_rd_en) both = 1'b1;
        if (bus.mem_wr_en != v.wr) both = 1'b1;
      end
      if (bus.resp_valid) begin
        lat = c;
        break;
      end
      step();
    end
    chk($sformatf("v%0d_latency", idx), 128'(lat), 128'(v.lat));
    chk($sformatf("v%0d_err", idx), 128'(bus.resp_err), 128'(v.err));
    chk($sformatf("v%0d_rdata", idx), bus.resp_rdata, v.rdata);
    chk($sformatf("v%0d_en_count", idx), 128'(en_cnt), 128'(exp_en));
    chk($sformatf("v%0d_en_kind", idx), 128'(both), 128'(0));
    if (!v.err) begin
      chk($sformatf("v%0d_first_addr", idx), 128'(first_addr), 128'(v.addr));
      chk($sformatf("v%0d_addr_hold", idx), 128'(bus.mem_addr),
          128'(v.addr + (v.pair ? 64'd1 : 64'd0)));
    end
    step();
    chk($sformatf("v%0d_ready_after", idx), 128'(bus.req_ready), 128'(1));
    chk($sformatf("v%0d_rdata_hold", idx), bus.resp_rdata, v.rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit got;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b1, 1'b0, 64'd5,   {64'h0, 64'hDEAD_BEEF},      2, 1'b0, 128'h0};
    vecs[1]  = '{1'b0, 1'b0, 64'd5,   128'h0,                      3, 1'b0, {64'h0, 64'hDEAD_BEEF}};
    vecs[2]  = '{1'b1, 1'b1, 64'd10,  {64'h2222, 64'h1111},        3, 1'b0, 128'h0};
    vecs[3]  = '{1'b0, 1'b1, 64'd10,  128'h0,                      5, 1'b0, {64'h2222, 64'h1111}};
    vecs[4]  = '{1'b0, 1'b0, 64'd256, 128'h0,                      1, 1'b1, 128'h0};
    vecs[5]  = '{1'b0, 1'b1, 64'd255, 128'h0,                      1, 1'b1, 128'h0};
    vecs[6]  = '{1'b1, 1'b1, 64'd254, {64'hBBBB, 64'hAAAA},        3, 1'b0, 128'h0};
    vecs[7]  = '{1'b0, 1'b1, 64'd254, 128'h0,                      5, 1'b0, {64'hBBBB, 64'hAAAA}};
    vecs[8]  = '{1'b0, 1'b0, 64'd11,  128'h0,                      3, 1'b0, {64'h0, 64'h2222}};
    vecs[9]  = '{1'b1, 1'b0, 64'd255, {64'h9999, 64'h55},          2, 1'b0, 128'h0};
    vecs[10] = '{1'b0, 1'b0, 64'd255, 128'h0,                      3, 1'b0, {64'h0, 64'h55}};
    vecs[11] = '{1'b1, 1'b1, 64'd255, {64'h1, 64'h2},              1, 1'b1, 128'h0};
    vecs[12] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 128'h3,      1, 1'b1, 128'h0};
    vecs[13] = '{1'b1, 1'b0, 64'd21,  {64'h0, 64'h7777},           2, 1'b0, 128'h0};
    vecs[14] = '{1'b0, 1'b0, 64'd254, 128'h0,                      3, 1'b0, {64'h0, 64'hAAAA}};

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_pair  = 1'b0;
    bus.req_addr  = 64'b0;
    bus.req_wdata = 128'b0;
    repeat (3) step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Request held valid across a busy pair load; second acceptance only after RESP.
    @(negedge clk);
    drive_req(1'b0, 1'b1, 64'd10, 128'h0);
    step();
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("hold_c%0d_ready", c), 128'(bus.req_ready), 128'(0));
      if (c == 5) chk("hold_c5_resp", 128'(bus.resp_valid), 128'(1));
      step();
    end
    chk("hold_c6_ready", 128'(bus.req_ready), 128'(1));
    chk("hold_c6_resp", 128'(bus.resp_valid), 128'(0));
    step();
    bus.req_valid = 1'b0;
    chk("hold_c7_rden", 128'(bus.mem_rd_en), 128'(1));
    chk("hold_c7_addr", 128'(bus.mem_addr), 128'(10));
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.resp_valid) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("hold_second_resp", 128'(got), 128'(1));
    chk("hold_second_rdata", bus.resp_rdata, {64'h2222, 64'h1111});
    step();

    // Reset while the hi half of a pair store is being issued.
    @(negedge clk);
    drive_req(1'b1, 1'b1, 64'd20, {64'h4444, 64'h3333});
    step();
    bus.req_valid = 1'b0;
    chk("rstmid_c1_wren", 128'(bus.mem_wr_en), 128'(1));
    chk("rstmid_c1_addr", 128'(bus.mem_addr), 128'(20));
    step();
    chk("rstmid_c2_addr", 128'(bus.mem_addr), 128'(21));
    rst = 1'b1;
    step();
    chk_reset_outputs("rstmid");
    chk("rstmid_mem_lo", 128'(mem[20]), 128'(64'h3333));
    chk("rstmid_mem_hi", 128'(mem[21]), 128'(64'h7777));
    rst = 1'b0;
    step();
    chk("rstmid_ready_after", 128'(bus.req_ready), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
